// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: A - B through one full-adder cell,
// LSB first, with a start/done handshake and borrow/overflow flags.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] ra_q,     ra_d;
  logic [WIDTH-1:0] rb_q,     rb_d;
  logic [WIDTH-1:0] res_q,    res_d;
  logic             carry_q,  carry_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic             aMsb_q,   aMsb_d;
  logic             bMsb_q,   bMsb_d;
  logic [WIDTH-1:0] diff_q,   diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q,    ovf_d;

  logic             bitSum;
  logic             bitCarry;
  logic [WIDTH-1:0] resNext;

  always_comb begin
    state_d  = state_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    res_d    = res_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    aMsb_d   = aMsb_q;
    bMsb_d   = bMsb_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;

    // Subtraction as A + ~B + 1: B inverted into the cell, carry preset to 1.
    bitSum   = ra_q[0] ^ ~rb_q[0] ^ carry_q;
    bitCarry = (ra_q[0] & ~rb_q[0]) | (ra_q[0] & carry_q) | (~rb_q[0] & carry_q);
    resNext  = {bitSum, res_q[WIDTH-1:1]};

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = SHIFT;
          ra_d    = a;
          rb_d    = b;
          carry_d = 1'b1;
          cnt_d   = '0;
          aMsb_d  = a[WIDTH-1];
          bMsb_d  = b[WIDTH-1];
        end
      end
      SHIFT: begin
        ra_d    = {1'b0, ra_q[WIDTH-1:1]};
        rb_d    = {1'b0, rb_q[WIDTH-1:1]};
        res_d   = resNext;
        carry_d = bitCarry;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d  = DONE;
          diff_d   = resNext;
          borrow_d = ~bitCarry;
          ovf_d    = (aMsb_q != bMsb_q) && (resNext[WIDTH-1] != aMsb_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ra_q     <= '0;
      rb_q     <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      aMsb_q   <= 1'b0;
      bMsb_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      aMsb_q   <= aMsb_d;
      bMsb_q   <= bMsb_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4) with hand-computed results;
// inputs driven and outputs sampled on the falling edge.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [3:0] diff;
  logic       borrow;
  logic       ovf;

  int compared   = 0;
  int mismatched = 0;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .ovf    (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    if (observed != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One full operation: pulse start, then time the done pulse and check flags.
  task automatic applyStimulus(input string tag, input logic [3:0] opA, input logic [3:0] opB,
                               input int expDiff, input int expBorrow, input int expOvf);
    int cycles;
    int busyCnt;
    @(negedge clk);
    a = opA; b = opB; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    busyCnt = 0;
    while (!done && cycles < 20) begin
      if (busy) busyCnt++;
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, "_latency"}, cycles, 4);
    checkOutput({tag, "_busyCycles"}, busyCnt, 4);
    checkOutput({tag, "_diff"}, int'(diff), expDiff);
    checkOutput({tag, "_borrow"}, int'(borrow), expBorrow);
    checkOutput({tag, "_ovf"}, int'(ovf), expOvf);
    @(negedge clk);
    checkOutput({tag, "_donePulseWidth"}, int'(done), 0);
    checkOutput({tag, "_diffHold"}, int'(diff), expDiff);
  endtask

  initial begin
    int cycles;
    int doneCnt;
    int seenDiff;
    int seenBorrow;
    int seenOvf;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_diff", int'(diff), 0);
    checkOutput("reset_borrow", int'(borrow), 0);
    checkOutput("reset_ovf", int'(ovf), 0);
    rst_n = 1'b1;

    applyStimulus("7m3", 4'd7, 4'd3, 4, 0, 0);
    applyStimulus("3m7", 4'd3, 4'd7, 12, 1, 0);
    applyStimulus("8m1", 4'd8, 4'd1, 7, 0, 1);
    applyStimulus("7mF", 4'd7, 4'hF, 8, 1, 1);
    applyStimulus("5m5", 4'd5, 4'd5, 0, 0, 0);
    applyStimulus("0m1", 4'd0, 4'd1, 15, 1, 0);
    applyStimulus("Am0", 4'hA, 4'd0, 10, 0, 0);

    // Stray start with new operands during SHIFT must be ignored.
    @(negedge clk);
    a = 4'd9; b = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'd1; b = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = '0; b = '0;
    doneCnt = 0; seenDiff = -1; seenBorrow = -1; seenOvf = -1;
    for (int i = 0; i < 14; i++) begin
      if (done) begin
        doneCnt++;
        seenDiff = int'(diff);
        seenBorrow = int'(borrow);
        seenOvf = int'(ovf);
      end
      @(negedge clk);
    end
    checkOutput("ignore_doneCount", doneCnt, 1);
    checkOutput("ignore_diff", seenDiff, 7);
    checkOutput("ignore_borrow", seenBorrow, 0);
    checkOutput("ignore_ovf", seenOvf, 1);

    // Start held through DONE launches the next operation with no idle cycle.
    a = 4'd4; b = 4'd1; start = 1'b1;
    @(negedge clk);
    a = 4'd2; b = 4'd6;
    cycles = 0;
    while (!done && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("b2b_first_diff", int'(diff), 3);
    checkOutput("b2b_first_borrow", int'(borrow), 0);
    @(negedge clk);
    checkOutput("b2b_noBubble", int'(busy), 1);
    start = 1'b0;
    cycles = 0;
    while (!done && cycles < 20) begin
      checkOutput("b2b_holdDiff", int'(diff), 3);
      @(negedge clk);
      cycles++;
    end
    checkOutput("b2b_latency", cycles, 4);
    checkOutput("b2b_second_diff", int'(diff), 12);
    checkOutput("b2b_second_borrow", int'(borrow), 1);
    checkOutput("b2b_second_ovf", int'(ovf), 0);
    @(negedge clk);

    // Reset on the third SHIFT cycle aborts the operation and clears outputs.
    a = 4'd3; b = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    checkOutput("abort_diff", int'(diff), 0);
    checkOutput("abort_borrow", int'(borrow), 0);
    checkOutput("abort_ovf", int'(ovf), 0);
    doneCnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) doneCnt++;
      @(negedge clk);
    end
    checkOutput("abort_noDone", doneCnt, 0);
    applyStimulus("6m1", 4'd6, 4'd1, 5, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
